// File: rtl/iob_cache_axi_read_arbiter_if.sv
// Bundle of the per-master cache read channels and the shared AXI read port.
//   m_*   : one lane per cache master. Address and length lanes are packed, with master k at slice k.
//           The R beat (rdata/rresp/rlast) is broadcast to every master; m_rvalid_o selects the owner.
//   axi_* : the single AXI AR/R channel pair that all masters share.
// Modports:
//   slave  : the arbiter's view of the bundle.
//   master : the environment's view, that is the cache masters plus the AXI slave.
interface iob_cache_axi_read_arbiter_if #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8
);
  logic [N_MASTERS-1:0]            m_arvalid_i;
  logic [N_MASTERS*AXI_ADDR_W-1:0] m_araddr_i;
  logic [N_MASTERS*AXI_LEN_W-1:0]  m_arlen_i;
  logic [N_MASTERS-1:0]            m_arready_o;
  logic [N_MASTERS-1:0]            m_rvalid_o;
  logic [N_MASTERS-1:0]            m_rready_i;
  logic [AXI_DATA_W-1:0]           m_rdata_o;
  logic [1:0]                      m_rresp_o;
  logic                            m_rlast_o;

  logic                            axi_arvalid_o;
  logic [AXI_ADDR_W-1:0]           axi_araddr_o;
  logic [AXI_LEN_W-1:0]            axi_arlen_o;
  logic                            axi_arready_i;
  logic                            axi_rvalid_i;
  logic [AXI_DATA_W-1:0]           axi_rdata_i;
  logic [1:0]                      axi_rresp_i;
  logic                            axi_rlast_i;
  logic                            axi_rready_o;

  modport slave (
    input  m_arvalid_i, m_araddr_i, m_arlen_i, m_rready_i,
    input  axi_arready_i, axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i,
    output m_arready_o, m_rvalid_o, m_rdata_o, m_rresp_o, m_rlast_o,
    output axi_arvalid_o, axi_araddr_o, axi_arlen_o, axi_rready_o
  );

  modport master (
    output m_arvalid_i, m_araddr_i, m_arlen_i, m_rready_i,
    output axi_arready_i, axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i,
    input  m_arready_o, m_rvalid_o, m_rdata_o, m_rresp_o, m_rlast_o,
    input  axi_arvalid_o, axi_araddr_o, axi_arlen_o, axi_rready_o
  );
endinterface

// File: rtl/iob_cache_axi_read_arbiter.sv
// Round-robin arbiter that lets N_MASTERS cache read channels share one AXI read port.
// At most one burst is outstanding at a time.
// Ports:
//   clk_i       : clock; all state changes on the rising edge.
//   reset_i     : asynchronous, active-high reset.
//   bus         : master lanes plus the shared AXI AR/R channels (slave modport).
//   grant_o     : index of the current owner; valid while busy_o is high.
//   busy_o      : high while a burst is in its address or data phase.
//   proto_err_o : sticky flag. It sets when the rlast position disagrees with the granted arlen.
module iob_cache_axi_read_arbiter #(
  parameter int unsigned N_MASTERS  = 2,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned AXI_LEN_W  = 8,
  localparam int unsigned GrantW    = $clog2(N_MASTERS)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  iob_cache_axi_read_arbiter_if.slave bus,
  output logic [GrantW-1:0]    grant_o,
  output logic                 busy_o,
  output logic                 proto_err_o
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                state_q, state_d;
  logic [GrantW-1:0]     grant_q, grant_d;
  logic [GrantW-1:0]     last_grant_q, last_grant_d;
  logic [AXI_LEN_W-1:0]  beat_len_q, beat_len_d;
  logic [AXI_LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  proto_err_q, proto_err_d;

  logic                  rr_found;
  logic [GrantW-1:0]     rr_pick;
  logic [AXI_LEN_W-1:0]  rr_len;
  logic [AXI_ADDR_W-1:0] sel_addr;
  logic [AXI_LEN_W-1:0]  sel_len;
  logic                  sel_rready;
  logic                  beat_acc;

  // Round-robin search. Offsets 1..N from last_grant_q are tried in order,
  // so the most recent owner is considered last.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_len   = '0;
    for (int unsigned j = 1; j <= N_MASTERS; j++) begin
      for (int unsigned k = 0; k < N_MASTERS; k++) begin
        if (!rr_found && bus.m_arvalid_i[k] &&
            ((32'(last_grant_q) + j) % N_MASTERS) == k) begin
          rr_found = 1'b1;
          rr_pick  = GrantW'(k);
          rr_len   = bus.m_arlen_i[k*AXI_LEN_W +: AXI_LEN_W];
        end
      end
    end
  end

  // Owner lane mux. The AR fields come from the live inputs, not from registered copies.
  always_comb begin
    sel_addr   = '0;
    sel_len    = '0;
    sel_rready = 1'b0;
    for (int unsigned k = 0; k < N_MASTERS; k++) begin
      if (grant_q == GrantW'(k)) begin
        sel_addr   = bus.m_araddr_i[k*AXI_ADDR_W +: AXI_ADDR_W];
        sel_len    = bus.m_arlen_i[k*AXI_LEN_W +: AXI_LEN_W];
        sel_rready = bus.m_rready_i[k];
      end
    end
  end

  assign beat_acc = (state_q == StData) && bus.axi_rvalid_i && sel_rready;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= GrantW'(N_MASTERS - 1);
      beat_len_q   <= '0;
      beat_cnt_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_len_q   <= beat_len_d;
      beat_cnt_q   <= beat_cnt_d;
      proto_err_q  <= proto_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_len_d   = beat_len_q;
    beat_cnt_d   = beat_cnt_q;
    proto_err_d  = proto_err_q;
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d    = rr_pick;
          beat_len_d = rr_len;
          state_d    = StAddr;
        end
      end
      StAddr: begin
        if (bus.axi_arready_i) begin
          beat_cnt_d = '0;
          state_d    = StData;
        end
      end
      StData: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + AXI_LEN_W'(1);
          if (bus.axi_rlast_i) begin
            if (beat_cnt_q != beat_len_q) proto_err_d = 1'b1;
            last_grant_d = grant_q;
            state_d      = StIdle;
          end else if (beat_cnt_q == beat_len_q) begin
            // The final beat arrived without rlast. Flag it, but let the slave
            // decide where the burst actually ends.
            proto_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.axi_arvalid_o = 1'b0;
    bus.axi_araddr_o  = sel_addr;
    bus.axi_arlen_o   = sel_len;
    bus.axi_rready_o  = 1'b0;
    bus.m_arready_o   = '0;
    bus.m_rvalid_o    = '0;
    unique case (state_q)
      StAddr: begin
        bus.axi_arvalid_o = 1'b1;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
          bus.m_arready_o[k] = (grant_q == GrantW'(k)) && bus.axi_arready_i;
        end
      end
      StData: begin
        bus.axi_rready_o = sel_rready;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
          bus.m_rvalid_o[k] = (grant_q == GrantW'(k)) && bus.axi_rvalid_i;
        end
      end
      default: ;
    endcase
  end

  assign bus.m_rdata_o = bus.axi_rdata_i;
  assign bus.m_rresp_o = bus.axi_rresp_i;
  assign bus.m_rlast_o = bus.axi_rlast_i;

  assign grant_o     = grant_q;
  assign busy_o      = (state_q != StIdle);
  assign proto_err_o = proto_err_q;

endmodule
